// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer and a flush that replaces all held entries with the configured bubble.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both
    // high; valid never waits on ready, and data is only meaningful while valid.
    // The state encoding equals the number of held entries, so occupancy doubles
    // as the observable FSM state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nx;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nx;
    logic             accept;
    logic             emit;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = state;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    if (SKID) begin : g_skid
        // Registered ready: depends only on state, never on out_ready.
        assign in_ready = (state != ST_FULL) && !rst;
    end else begin : g_noskid
        assign in_ready = (out_ready || !out_valid) && !rst;
    end

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx = ST_ONE;
                    main_nx  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_nx = in_data;
                end else if (emit) begin
                    state_nx = ST_EMPTY;
                end else if (accept) begin
                    // Only reachable with SKID=1: without skid, accept in ONE implies emit.
                    state_nx = ST_FULL;
                    skid_nx  = in_data;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_nx = ST_ONE;
                    main_nx  = skid_q;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        if (flush) begin
            state_nx = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a no-skid instance, each tracked by
// an in-order expected queue filled on accept and drained on emit.
module tb_pipe_stage_reg;

    localparam int unsigned W   = 32;
    localparam logic [W-1:0] BUB = 32'h0000_0013;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    logic         flush_b;
    logic         in_valid_b;
    logic         in_ready_b;
    logic [W-1:0] in_data_b;
    logic         out_valid_b;
    logic         out_ready_b;
    logic [W-1:0] out_data_b;
    logic [1:0]   occupancy_b;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q_b[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] exp_v_b;
    int           vectors = 0;
    int           errors  = 0;
    bit           mon_en  = 1'b0;

    pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occupancy_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL a_order: got %h, expected no output", out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL a_order: got %h, expected %h", out_data, exp_v);
                    end
                end
            end
            if (!out_valid) begin
                vectors++;
                if (out_data !== BUB) begin
                    errors++;
                    $display("FAIL a_bubble: got %h, expected %h", out_data, BUB);
                end
            end
            if (rst || flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid_b && out_ready_b) begin
                vectors++;
                if (exp_q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_order: got %h, expected no output", out_data_b);
                end else begin
                    exp_v_b = exp_q_b.pop_front();
                    if (out_data_b !== exp_v_b) begin
                        errors++;
                        $display("FAIL b_order: got %h, expected %h", out_data_b, exp_v_b);
                    end
                end
            end
            if (rst || flush_b) exp_q_b.delete();
            else if (in_valid_b && in_ready_b) exp_q_b.push_back(in_data_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: rdy=%b vld=%b data=%h occ=%0d, expected 0 0 %h 0",
                         in_ready, out_valid, out_data, occupancy, BUB);
            end
            tick();
            mon_en = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== BUB || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: rdy=%b rdy_b=%b vld=%b data=%h, expected 1 1 0 %h",
                     in_ready, in_ready_b, out_valid, out_data, BUB);
        end
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            @(negedge clk);
            vectors++;
            if (i == 1) begin
                if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_first: occ=%0d vld=%b, expected 0 0", occupancy, out_valid);
                end
            end else if (occupancy !== 2'd1 || out_data !== W'(i - 1)) begin
                errors++;
                $display("FAIL stream_latency: occ=%0d data=%h, expected 1 %h", occupancy, out_data, W'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h8) begin
            errors++;
            $display("FAIL stream_last: vld=%b data=%h, expected 1 00000008", out_valid, out_data);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: occ=%0d pending=%0d, expected 0 0", occupancy, exp_q.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_data !== 32'hA) begin
            errors++;
            $display("FAIL bp_one: rdy=%b occ=%0d data=%h, expected 1 1 0000000a", in_ready, occupancy, out_data);
        end
        tick();
        in_data = 32'hC;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'hA) begin
            errors++;
            $display("FAIL bp_full: rdy=%b occ=%0d data=%h, expected 0 2 0000000a", in_ready, occupancy, out_data);
        end
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_data !== 32'hB) begin
            errors++;
            $display("FAIL bp_release: rdy=%b occ=%0d data=%h, expected 1 1 0000000b", in_ready, occupancy, out_data);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        repeat (2) tick();
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: occ=%0d pending=%0d, expected 0 0", occupancy, exp_q.size());
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_data = 32'hD;
        flush   = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_full_pre: rdy=%b occ=%0d, expected 0 2", in_ready, occupancy);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: occ=%0d vld=%b data=%h rdy=%b, expected 0 0 %h 1",
                     occupancy, out_valid, out_data, in_ready, BUB);
        end
        // Flush in ONE with a same-cycle emit (completes) and accept (dropped).
        in_valid = 1'b1;
        in_data  = 32'h21;
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = 32'hE;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: rdy=%b, expected 1", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_one: occ=%0d vld=%b, expected 0 0", occupancy, out_valid);
        end
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet: pending=%0d vld=%b, expected 0 0", exp_q.size(), out_valid);
        end
        tick();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h33;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL rstfull_pre: rdy=%b occ=%0d, expected 0 2", in_ready, occupancy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUB || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_held: vld=%b occ=%0d data=%h rdy=%b, expected 0 0 %h 0",
                     out_valid, occupancy, out_data, in_ready, BUB);
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rstfull_release: rdy=%b occ=%0d, expected 1 0", in_ready, occupancy);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [1:0] mdl_occ;
        logic       acc;
        logic       emt;
        mdl_occ = 2'd0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            vectors++;
            if (occupancy !== mdl_occ || in_ready !== (mdl_occ != 2'd2)) begin
                errors++;
                $display("FAIL rand_state: occ=%0d rdy=%b, expected %0d %b",
                         occupancy, in_ready, mdl_occ, (mdl_occ != 2'd2));
            end
            acc = in_valid && (mdl_occ != 2'd2);
            emt = out_ready && (mdl_occ != 2'd0);
            if (flush) mdl_occ = 2'd0;
            else       mdl_occ = mdl_occ + {1'b0, acc} - {1'b0, emt};
            tick();
        end
        in_valid  = 1'b0;
        in_data   = 'x;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rand_drain: pending=%0d occ=%0d, expected 0 0", exp_q.size(), occupancy);
        end
        tick();
    endtask

    task automatic test_noskid();
        logic         mdl_vb;
        logic         exp_rdy;
        logic [W-1:0] data_b;
        mdl_vb = 1'b0;
        data_b = 32'h100;
        for (int i = 0; i < 40; i++) begin
            in_valid_b  = 1'b1;
            in_data_b   = data_b;
            out_ready_b = (i < 12) ? i[0] : ($urandom_range(0, 1) == 1);
            @(negedge clk);
            exp_rdy = out_ready_b || !mdl_vb;
            vectors++;
            if (in_ready_b !== exp_rdy || out_valid_b !== mdl_vb || occupancy_b !== {1'b0, mdl_vb}) begin
                errors++;
                $display("FAIL noskid_ready: rdy=%b vld=%b occ=%0d, expected %b %b %0d",
                         in_ready_b, out_valid_b, occupancy_b, exp_rdy, mdl_vb, mdl_vb);
            end
            mdl_vb = exp_rdy || (mdl_vb && !out_ready_b);
            if (exp_rdy) data_b = data_b + 1;
            tick();
        end
        in_valid_b  = 1'b0;
        in_data_b   = 'x;
        out_ready_b = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        vectors++;
        if (exp_q_b.size() != 0 || out_valid_b !== 1'b0 || out_data_b !== BUB) begin
            errors++;
            $display("FAIL noskid_drain: pending=%0d vld=%b data=%h, expected 0 0 %h",
                     exp_q_b.size(), out_valid_b, out_data_b, BUB);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush_b     = 1'b0;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        out_ready_b = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_full();
        test_random();
        test_noskid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
